lut_arbiter: RTL and testbench
==============================

// Module: lut_arbiter
// PURPOSE
//  Shares one activation LUT (lut; NEURON_NUM parallel lookups) between two requesters:
//  port 0 = forward-pass activation, port 1 = backprop derivative lookup.
//  Accepts one request vector, issues it to the LUT, captures the LUT result and returns
//  it to the requester that issued it. Round-robin grant; one transaction in flight.
// PARAMETERS
//  NEURON_NUM     6   lookups per vector; must match the attached lut
//  LUT_ADDR_SIZE  10  address bits per lookup
//  LUT_WIDTH      9   data bits per lookup result
// PORTS
//  clk             in   1       clock; all state changes on rising edge
//  rst             in   1       reset, asynchronous, active-high
//  req0_inputs     in   N*A     port-0 address vector (N=NEURON_NUM, A=LUT_ADDR_SIZE)
//  req0_valid      in   1       port-0 request valid
//  req0_ready      out  1       port-0 request accepted this cycle
//  req1_inputs/_valid/_ready    as port 0, for port 1
//  resp0_outputs   out  N*W     port-0 result vector (W=LUT_WIDTH)
//  resp0_valid     out  1       port-0 result valid
//  resp0_ready     in   1       port-0 consumer ready
//  resp1_outputs/_valid/_ready  as port 0, for port 1
//  lut_inputs      out  N*A     to lut inputs
//  lut_inputs_valid out 1       to lut inputs_valid
//  lut_inputs_ready in  1       from lut inputs_ready
//  lut_outputs     in   N*W     from lut outputs
//  lut_outputs_valid in 1       from lut outputs_valid
//  lut_outputs_ready out 1      to lut outputs_ready
//  grant           out  1       id of port owning the current transaction
//  busy            out  1       high in every state except IDLE
// BEHAVIOUR
//  Reset (async, rst high): state=IDLE, last_grant=1 (port 0 wins first tie), grant=0,
//   request/result buffers=0; every valid/ready output 0 while rst high (ready gated).
//  States IDLE -> ISSUE -> WAIT -> RETURN -> IDLE.
//  IDLE: pick = only valid port; if both valid, port != last_grant. reqX_ready=1
//   combinationally for picked port only; on that handshake latch reqX_inputs into
//   req buffer, grant<=pick, -> ISSUE. No valid: stay IDLE, all readies 0.
//  ISSUE: lut_inputs=req buffer, lut_inputs_valid=1; on lut_inputs_ready -> WAIT.
//  WAIT: lut_outputs_ready=1; on lut_outputs_valid latch lut_outputs into result
//   buffer -> RETURN. lut_outputs_valid in any other state ignored (ready 0).
//  RETURN: respG_valid=1 for G=grant only, respG_outputs=result buffer; other resp
//   valid 0. On respG_ready: last_grant<=grant, -> IDLE.
//  Latency: accept T; lut_inputs_valid T+1; earliest resp valid one cycle after LUT
//   result handshake. Min one IDLE cycle between transactions (no back-to-back accept).
//  respX_outputs are driven from the result buffer in all states (held, not cleared).
//  Requester may drop valid before accept; nothing is latched. Inputs sampled only at accept.
//  resp_ready held low: stay in RETURN indefinitely; no new request accepted.
//  Single active requester: served every transaction, no stall waiting for the other.
//  rst mid-transaction: immediate IDLE, in-flight result discarded; the lut must be
//   reset by the same rst so it does not emit a stale result later.
// STRUCTURE
//  Shared include (lut_arbiter_defs.v): state encodings IDLE/ISSUE/WAIT/RETURN and
//   port-id constants, reused by the layer controller that drives the requesters.
//  One sub-module: rr_pick2 (combinational 2-way round-robin picker: valid[1:0],
//   last -> pick, any). Buffers, state register and muxing stay in lut_arbiter.
// TESTING (bench: lut_arbiter + real lut, init file data[addr]=addr[8:0]; N=6,A=10,W=9)
//  1 Port 0 alone, addresses {5,4,3,2,1,0} -> resp0_valid with {5,4,3,2,1,0}; resp1_valid
//    never rises; grant=0.
//  2 Both valid every cycle from reset, distinct vectors -> grants 0,1,0,1; each result
//    returned only on its own port and matches its own request.
//  3 resp1_ready held low 20 cycles -> resp1_valid/outputs stable, req0_ready stays 0,
//    busy=1; release -> IDLE next cycle, then port 0 served.
//  4 Port 1 valid continuously, port 0 idle -> three consecutive port-1 grants, each
//    separated by exactly one IDLE cycle.
//  5 rst pulse during WAIT -> all valid/ready 0 at once, busy=0, grant=0; next request
//    returns correct fresh data, no stale result delivered.
//  6 req0_valid high 1 cycle while in ISSUE then dropped -> never accepted, no response.

Source files
------------

// File: rtl/lut_arbiter_pkg.sv
// Shared constants for the LUT arbiter: FSM state encodings and requester port ids,
// also used by the layer controller that drives the requesters.
package lut_arbiter_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RETURN = 2'd3;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/lut_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: a lone valid port wins; on a tie the
// port that was not granted last time wins.
module rr_pick2
  import lut_arbiter_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       last_i,
  output logic       pick_o,
  output logic       any_o
);

  always_comb begin
    any_o  = |valid_i;
    pick_o = PORT0;
    if (valid_i == 2'b11) begin
      pick_o = ~last_i;
    end else if (valid_i[1]) begin
      pick_o = PORT1;
    end
  end

endmodule

// File: rtl/lut_arbiter.sv
// Shares one activation LUT between forward (port 0) and backprop (port 1) requesters,
// one transaction in flight, round-robin grant, result returned to the issuing port.
module lut_arbiter
  import lut_arbiter_pkg::*;
#(
  parameter int NEURON_NUM    = 6,
  parameter int LUT_ADDR_SIZE = 10,
  parameter int LUT_WIDTH     = 9
)
(
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NEURON_NUM*LUT_ADDR_SIZE-1:0] req0_inputs,
  input  logic                                req0_valid,
  output logic                                req0_ready,
  input  logic [NEURON_NUM*LUT_ADDR_SIZE-1:0] req1_inputs,
  input  logic                                req1_valid,
  output logic                                req1_ready,
  output logic [NEURON_NUM*LUT_WIDTH-1:0]     resp0_outputs,
  output logic                                resp0_valid,
  input  logic                                resp0_ready,
  output logic [NEURON_NUM*LUT_WIDTH-1:0]     resp1_outputs,
  output logic                                resp1_valid,
  input  logic                                resp1_ready,
  output logic [NEURON_NUM*LUT_ADDR_SIZE-1:0] lut_inputs,
  output logic                                lut_inputs_valid,
  input  logic                                lut_inputs_ready,
  input  logic [NEURON_NUM*LUT_WIDTH-1:0]     lut_outputs,
  input  logic                                lut_outputs_valid,
  output logic                                lut_outputs_ready,
  output logic                                grant,
  output logic                                busy,
  output logic [1:0]                          dbg_state
);

  localparam int AW = NEURON_NUM * LUT_ADDR_SIZE;
  localparam int DW = NEURON_NUM * LUT_WIDTH;

  logic [1:0]    state_q, state_d;
  logic          grant_q, grant_d;
  logic          last_q, last_d;
  logic [AW-1:0] req_buf_q, req_buf_d;
  logic [DW-1:0] res_buf_q, res_buf_d;

  logic pick;
  logic any_valid;
  logic resp_ready_sel;

  rr_pick2 u_pick (
    .valid_i ({req1_valid, req0_valid}),
    .last_i  (last_q),
    .pick_o  (pick),
    .any_o   (any_valid)
  );

  assign lut_inputs     = req_buf_q;
  assign resp0_outputs  = res_buf_q;
  assign resp1_outputs  = res_buf_q;
  assign grant          = grant_q;
  assign busy           = (state_q != ST_IDLE);
  assign dbg_state      = state_q;
  assign resp_ready_sel = grant_q ? resp1_ready : resp0_ready;

  // Every channel uses valid/ready: a transfer happens on a rising edge where both are
  // high; readies here are raised only in the state that can take the transfer.
  always_comb begin
    state_d           = state_q;
    grant_d           = grant_q;
    last_d            = last_q;
    req_buf_d         = req_buf_q;
    res_buf_d         = res_buf_q;
    req0_ready        = 1'b0;
    req1_ready        = 1'b0;
    lut_inputs_valid  = 1'b0;
    lut_outputs_ready = 1'b0;
    resp0_valid       = 1'b0;
    resp1_valid       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // rst gating: IDLE is the reset state, so this is the only ready seen under rst
        if (!rst && any_valid) begin
          req0_ready = (pick == PORT0);
          req1_ready = (pick == PORT1);
          req_buf_d  = (pick == PORT1) ? req1_inputs : req0_inputs;
          grant_d    = pick;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        lut_inputs_valid = 1'b1;
        if (lut_inputs_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        lut_outputs_ready = 1'b1;
        if (lut_outputs_valid) begin
          res_buf_d = lut_outputs;
          state_d   = ST_RETURN;
        end
      end
      ST_RETURN: begin
        resp0_valid = (grant_q == PORT0);
        resp1_valid = (grant_q == PORT1);
        if (resp_ready_sel) begin
          last_d  = grant_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= PORT0;
      last_q    <= PORT1;
      req_buf_q <= '0;
      res_buf_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      req_buf_q <= req_buf_d;
      res_buf_q <= res_buf_d;
    end
  end

endmodule

// File: tb/tb_lut_arbiter.sv
// Bench for lut_arbiter with a behavioural LUT (data[addr] = addr[8:0]), directed
// requests and a response scoreboard.
module tb_lut_arbiter;
  import lut_arbiter_pkg::*;

  localparam int N  = 6;
  localparam int A  = 10;
  localparam int W  = 9;
  localparam int AW = N * A;
  localparam int DW = N * W;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] req0_inputs = '0;
  logic          req0_valid  = 1'b0;
  logic          req0_ready;
  logic [AW-1:0] req1_inputs = '0;
  logic          req1_valid  = 1'b0;
  logic          req1_ready;
  logic [DW-1:0] resp0_outputs;
  logic          resp0_valid;
  logic          resp0_ready = 1'b1;
  logic [DW-1:0] resp1_outputs;
  logic          resp1_valid;
  logic          resp1_ready = 1'b1;
  logic [AW-1:0] lut_inputs;
  logic          lut_inputs_valid;
  logic          lut_inputs_ready;
  logic [DW-1:0] lut_outputs;
  logic          lut_outputs_valid;
  logic          lut_outputs_ready;
  logic          grant;
  logic          busy;
  logic [1:0]    dbg_state;

  lut_arbiter #(.NEURON_NUM(N), .LUT_ADDR_SIZE(A), .LUT_WIDTH(W)) dut (
    .clk               (clk),
    .rst               (rst),
    .req0_inputs       (req0_inputs),
    .req0_valid        (req0_valid),
    .req0_ready        (req0_ready),
    .req1_inputs       (req1_inputs),
    .req1_valid        (req1_valid),
    .req1_ready        (req1_ready),
    .resp0_outputs     (resp0_outputs),
    .resp0_valid       (resp0_valid),
    .resp0_ready       (resp0_ready),
    .resp1_outputs     (resp1_outputs),
    .resp1_valid       (resp1_valid),
    .resp1_ready       (resp1_ready),
    .lut_inputs        (lut_inputs),
    .lut_inputs_valid  (lut_inputs_valid),
    .lut_inputs_ready  (lut_inputs_ready),
    .lut_outputs       (lut_outputs),
    .lut_outputs_valid (lut_outputs_valid),
    .lut_outputs_ready (lut_outputs_ready),
    .grant             (grant),
    .busy              (busy),
    .dbg_state         (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  logic [DW:0]   exp_q[$];
  logic [AW-1:0] q0[$];
  logic [AW-1:0] q1[$];

  function automatic logic [AW-1:0] mk_a(input int a5, a4, a3, a2, a1, a0);
    return {10'(a5), 10'(a4), 10'(a3), 10'(a2), 10'(a1), 10'(a0)};
  endfunction

  function automatic logic [DW-1:0] mk_w(input int w5, w4, w3, w2, w1, w0);
    return {9'(w5), 9'(w4), 9'(w3), 9'(w2), 9'(w1), 9'(w0)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // behavioural LUT, reset by the same rst as the arbiter
  logic          lut_busy_q = 1'b0;
  int            lut_cnt    = 0;
  int            lut_lat    = 2;
  logic          in_rdy_en  = 1'b1;
  logic [DW-1:0] lut_data_q = '0;

  function automatic logic [DW-1:0] lut_f(input logic [AW-1:0] a);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*W +: W] = a[i*A +: W];
    return r;
  endfunction

  assign lut_inputs_ready  = in_rdy_en && !lut_busy_q;
  assign lut_outputs_valid = lut_busy_q && (lut_cnt == 0);
  assign lut_outputs       = lut_data_q;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      lut_busy_q <= 1'b0;
      lut_cnt    <= 0;
      lut_data_q <= '0;
    end else if (!lut_busy_q && lut_inputs_valid && in_rdy_en) begin
      lut_busy_q <= 1'b1;
      lut_cnt    <= lut_lat;
      lut_data_q <= lut_f(lut_inputs);
    end else if (lut_busy_q && lut_cnt > 0) begin
      lut_cnt <= lut_cnt - 1;
    end else if (lut_busy_q && lut_outputs_ready) begin
      lut_busy_q <= 1'b0;
    end
  end

  // driver: requests presented from per-port queues, handshakes sampled mid-cycle
  logic          hs0 = 1'b0;
  logic          hs1 = 1'b0;
  logic          man0 = 1'b0;
  logic          raw0_v = 1'b0;
  logic [AW-1:0] raw0_a = '0;

  always @(negedge clk) begin
    hs0 = req0_valid && req0_ready;
    hs1 = req1_valid && req1_ready;
  end

  always @(posedge clk) begin
    #1;
    if (hs0 && q0.size() > 0) void'(q0.pop_front());
    if (man0) begin
      req0_valid  = raw0_v;
      req0_inputs = raw0_a;
    end else if (q0.size() > 0) begin
      req0_valid  = 1'b1;
      req0_inputs = q0[0];
    end else begin
      req0_valid = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (hs1 && q1.size() > 0) void'(q1.pop_front());
    if (q1.size() > 0) begin
      req1_valid  = 1'b1;
      req1_inputs = q1[0];
    end else begin
      req1_valid = 1'b0;
    end
  end

  // scoreboard monitor
  task automatic pop_cmp(input logic port, input logic [DW-1:0] data);
    logic [DW:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL resp_unexpected: port %0d data %0h with nothing expected", port, data);
    end else begin
      e = exp_q.pop_front();
      check("resp_port", 64'(port), 64'(e[DW]));
      check("resp_data", 64'(data), 64'(e[DW-1:0]));
      check("resp_grant", 64'(grant), 64'(e[DW]));
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (resp0_valid && resp1_valid) check("resp_both_valid", 64'(1), 64'(0));
      if (resp0_valid && resp0_ready) pop_cmp(PORT0, resp0_outputs);
      if (resp1_valid && resp1_ready) pop_cmp(PORT1, resp1_outputs);
    end
  end

  task automatic send(input logic port, input logic [AW-1:0] a, input logic [DW-1:0] w);
    if (port) q1.push_back(a);
    else q0.push_back(a);
    exp_q.push_back({port, w});
  endtask

  task automatic wait_state(input logic [1:0] st, input string name);
    int n = 0;
    while (dbg_state !== st && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check(name, 64'(dbg_state), 64'(st));
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((q0.size() + q1.size() + exp_q.size() != 0 || dbg_state !== ST_IDLE) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check(name, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    @(negedge clk);
    check("rst_handshakes",
          64'({req0_ready, req1_ready, resp0_valid, resp1_valid, lut_inputs_valid, lut_outputs_ready}),
          64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_grant", 64'(grant), 64'(0));
    check("rst_resp_out", 64'(resp0_outputs), 64'(0));
    check("rst_lut_in", 64'(lut_inputs), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // 1: port 0 alone
    send(PORT0, mk_a(5, 4, 3, 2, 1, 0), mk_w(5, 4, 3, 2, 1, 0));
    wait_state(ST_ISSUE, "t1_issue_timeout");
    check("t1_grant", 64'(grant), 64'(0));
    check("t1_lut_in", 64'(lut_inputs), 64'(mk_a(5, 4, 3, 2, 1, 0)));
    wait_drain("t1_drain_timeout");

    // 2: both ports from reset, alternating grants starting at port 0
    rst = 1'b1;
    send(PORT0, mk_a(10, 20, 30, 40, 50, 60), mk_w(10, 20, 30, 40, 50, 60));
    send(PORT1, mk_a(511, 512, 1023, 256, 7, 100), mk_w(511, 0, 511, 256, 7, 100));
    send(PORT0, mk_a(700, 600, 513, 1, 2, 3), mk_w(188, 88, 1, 1, 2, 3));
    send(PORT1, mk_a(0, 0, 0, 0, 0, 1), mk_w(0, 0, 0, 0, 0, 1));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_drain("t2_drain_timeout");

    // 3: port 1 result held back while port 0 waits
    resp1_ready = 1'b0;
    send(PORT1, mk_a(9, 8, 7, 6, 5, 4), mk_w(9, 8, 7, 6, 5, 4));
    wait_state(ST_RETURN, "t3_return_timeout");
    send(PORT0, mk_a(1000, 999, 998, 997, 996, 995), mk_w(488, 487, 486, 485, 484, 483));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("t3_stall_ctl", 64'({resp1_valid, req0_ready, busy}), 64'(3'b101));
      check("t3_stall_data", 64'(resp1_outputs), 64'(mk_w(9, 8, 7, 6, 5, 4)));
    end
    @(posedge clk);
    #1 resp1_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t3_idle_after_release", 64'(dbg_state), 64'(ST_IDLE));
    check("t3_port0_ready", 64'(req0_ready), 64'(1));
    wait_drain("t3_drain_timeout");

    // 4: port 1 alone, back-to-back requests
    send(PORT1, mk_a(11, 12, 13, 14, 15, 16), mk_w(11, 12, 13, 14, 15, 16));
    send(PORT1, mk_a(300, 301, 302, 303, 304, 305), mk_w(300, 301, 302, 303, 304, 305));
    send(PORT1, mk_a(1023, 1022, 1021, 1020, 1019, 1018), mk_w(511, 510, 509, 508, 507, 506));
    begin
      int acc = 0;
      int idle_run = 0;
      int cyc = 0;
      while (acc < 3 && cyc < 400) begin
        @(negedge clk);
        cyc++;
        if (dbg_state == ST_IDLE) idle_run++;
        else idle_run = 0;
        if (req1_valid && req1_ready) begin
          acc++;
          if (acc > 1) check("t4_idle_gap", 64'(idle_run), 64'(1));
        end
      end
      check("t4_accepts", 64'(acc), 64'(3));
    end
    wait_drain("t4_drain_timeout");

    // 5: reset while the LUT lookup is outstanding
    lut_lat = 6;
    q1.push_back(mk_a(42, 43, 44, 45, 46, 47));
    wait_state(ST_WAIT, "t5_wait_timeout");
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_handshakes",
          64'({req0_ready, req1_ready, resp0_valid, resp1_valid, lut_inputs_valid, lut_outputs_ready}),
          64'(0));
    check("t5_rst_busy", 64'(busy), 64'(0));
    check("t5_rst_grant", 64'(grant), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    lut_lat = 2;
    send(PORT1, mk_a(77, 78, 79, 80, 81, 82), mk_w(77, 78, 79, 80, 81, 82));
    wait_drain("t5_drain_timeout");

    // 6: port 0 pulses valid while port 1 holds the LUT in ISSUE
    in_rdy_en = 1'b0;
    send(PORT1, mk_a(21, 22, 23, 24, 25, 26), mk_w(21, 22, 23, 24, 25, 26));
    wait_state(ST_ISSUE, "t6_issue_timeout");
    man0   = 1'b1;
    raw0_a = mk_a(1, 1, 1, 1, 1, 1);
    raw0_v = 1'b1;
    @(negedge clk);
    check("t6_no_ready", 64'(req0_ready), 64'(0));
    check("t6_issue_ctl", 64'({busy, lut_inputs_valid}), 64'(2'b11));
    raw0_v = 1'b0;
    @(negedge clk);
    man0      = 1'b0;
    in_rdy_en = 1'b1;
    wait_drain("t6_drain_timeout");
    repeat (10) @(negedge clk);
    check("t6_final_idle", 64'(dbg_state), 64'(ST_IDLE));
    check("t6_no_pending", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
